// File: rtl/y_alu_pkg.sv
// Shared definitions for y_seq_alu: op codes, FSM encoding, multiply/divide mode
// and divide-by-zero result constants.
package y_alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MULT  = 4'b1000;
  localparam logic [3:0] OP_MULTU = 4'b1001;
  localparam logic [3:0] OP_DIV   = 4'b1010;
  localparam logic [3:0] OP_DIVU  = 4'b1011;

  typedef enum logic [1:0] {StIdle, StIter, StFin} state_e;

  typedef enum logic {MduMul, MduDiv} mdu_mode_e;

  // Divide by zero: quotient is replicated from this bit, remainder is the raw dividend.
  localparam logic DIVZ_LO_BIT = 1'b1;

endpackage

// File: rtl/y_mdu_iter.sv
// Iterative multiply/divide datapath: one shift-add or restoring subtract-shift
// step per cycle on unsigned magnitudes. hi/lo hold the raw magnitude results.
module y_mdu_iter
  import y_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  mdu_mode_e        mode_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH-1:0] hi_q, lo_q, m_q;
  logic [WIDTH-1:0] hi_d, lo_d;
  logic [WIDTH:0]   sum, rem_sh, trial;

  always_comb begin
    sum    = '0;
    rem_sh = '0;
    trial  = '0;
    hi_d   = hi_q;
    lo_d   = lo_q;
    if (mode_i == MduMul) begin
      // lo doubles as multiplier shift register; the carry shifts into hi's MSB.
      sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
      hi_d = sum[WIDTH:1];
      lo_d = {sum[0], lo_q[WIDTH-1:1]};
    end else begin
      rem_sh = {hi_q, lo_q[WIDTH-1]};
      trial  = rem_sh - {1'b0, m_q};
      if (!trial[WIDTH]) begin
        hi_d = trial[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_d = rem_sh[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
      m_q  <= '0;
    end else if (load_i) begin
      hi_q <= '0;
      lo_q <= a_i;
      m_q  <= b_i;
    end else if (step_i) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/y_seq_alu.sv
// Registered ALU with start/done handshake and iterative MULT/DIV into HI/LO.
// Optional signed-overflow flag output enabled by Y_SEQ_ALU_OVF_EN.
module y_seq_alu
  import y_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
`ifdef Y_SEQ_ALU_OVF_EN
  ,
  output logic             ovf
`endif
);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q, done_q, zero_q;
  logic [WIDTH-1:0] z_q, hi_q, lo_q, a_q;
  mdu_mode_e        mode_q;
  logic             neg_q, rneg_q, bzero_q;

  logic             is_md, op_sgn, mdu_load, mdu_step;
  logic [WIDTH-1:0] a_mag, b_mag, mdu_hi, mdu_lo;
  logic [WIDTH-1:0] sum, diff, alu_z;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] fin_hi, fin_lo;

  assign is_md    = (op[3:2] == 2'b10);
  assign op_sgn   = ~op[0];
  assign a_mag    = (op_sgn && a[WIDTH-1]) ? -a : a;
  assign b_mag    = (op_sgn && b[WIDTH-1]) ? -b : b;
  assign mdu_load = (state_q == StIdle) && start && is_md;
  assign mdu_step = (state_q == StIter);

  y_mdu_iter #(
    .WIDTH (WIDTH)
  ) u_mdu (
    .clk    (clk),
    .rst    (rst),
    .mode_i (mode_q),
    .load_i (mdu_load),
    .step_i (mdu_step),
    .a_i    (a_mag),
    .b_i    (b_mag),
    .hi_o   (mdu_hi),
    .lo_o   (mdu_lo)
  );

  always_comb begin
    sum   = a + b;
    diff  = a - b;
    alu_z = '0;
    case (op)
      OP_AND:  alu_z = a & b;
      OP_OR:   alu_z = a | b;
      OP_ADD:  alu_z = sum;
      OP_SUB:  alu_z = diff;
      OP_SLT:  alu_z = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      default: alu_z = '0;
    endcase
  end

  // Sign correction of the magnitude results on the way out of FIN.
  always_comb begin
    prod = neg_q ? -{mdu_hi, mdu_lo} : {mdu_hi, mdu_lo};
    if (mode_q == MduMul) begin
      fin_hi = prod[2*WIDTH-1:WIDTH];
      fin_lo = prod[WIDTH-1:0];
    end else if (bzero_q) begin
      fin_hi = a_q;
      fin_lo = {WIDTH{DIVZ_LO_BIT}};
    end else begin
      fin_hi = rneg_q ? -mdu_hi : mdu_hi;
      fin_lo = neg_q ? -mdu_lo : mdu_lo;
    end
  end

`ifdef Y_SEQ_ALU_OVF_EN
  logic alu_ovf, ovf_q;
  assign alu_ovf = ((op == OP_ADD) && (a[WIDTH-1] == b[WIDTH-1]) &&
                    (sum[WIDTH-1] != a[WIDTH-1])) ||
                   ((op == OP_SUB) && (a[WIDTH-1] != b[WIDTH-1]) &&
                    (diff[WIDTH-1] != a[WIDTH-1]));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (state_q == StIdle && start && !is_md) begin
      ovf_q <= alu_ovf;
    end else if (state_q == StFin) begin
      ovf_q <= 1'b0;
    end
  end
  assign ovf = ovf_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      z_q     <= '0;
      zero_q  <= 1'b1;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      mode_q  <= MduMul;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      bzero_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start && is_md) begin
            state_q <= StIter;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            a_q     <= a;
            mode_q  <= op[1] ? MduDiv : MduMul;
            neg_q   <= op_sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
            rneg_q  <= op_sgn && a[WIDTH-1];
            bzero_q <= (b == '0);
          end else if (start) begin
            z_q    <= alu_z;
            zero_q <= (alu_z == '0);
            done_q <= 1'b1;
          end
        end
        StIter: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= StFin;
        end
        StFin: begin
          state_q <= StIdle;
          hi_q    <= fin_hi;
          lo_q    <= fin_lo;
          z_q     <= fin_lo;
          zero_q  <= (fin_lo == '0);
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign z    = z_q;
  assign zero = zero_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/y_seq_alu.md
Name: y_seq_alu

Overview:
- Parametrised, registered successor to the single-cycle combinational ALU.
- Adds WIDTH generalisation, a start/done handshake, iterative signed/unsigned multiply and divide, and architectural HI/LO registers.
- Sits in the EX stage of the multi-cycle datapath; control stalls PC/IR update while busy is high.

Parameters:
- WIDTH, 32: operand/result width in bits; must be >= 4.
- CNT_W, $clog2(WIDTH)+1: iteration counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  launch op; sampled only in IDLE
- op  input  4  operation code (see Behaviour)
- a  input  WIDTH  operand A (rs)
- b  input  WIDTH  operand B (rt or imm)
- busy  output  1  high while an iterative op is in progress
- done  output  1  one-cycle pulse when z/hi/lo are valid
- z  output  WIDTH  registered result
- zero  output  1  registered (z == 0)
- hi  output  WIDTH  HI register (product upper half / remainder)
- lo  output  WIDTH  LO register (product lower half / quotient)

Behaviour:
- Reset (async, immediate): state=IDLE; busy=0, done=0, z=0, zero=1, hi=0, lo=0, counter=0.
- Op codes:
  - Legacy-compatible, op[3]=0: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed).
  - 1000 MULT, 1001 MULTU, 1010 DIV, 1011 DIVU.
  - Any other code: z=0, done pulses after 1 cycle, hi/lo unchanged.
- FSM states IDLE, ITER, FIN:
  - IDLE & start & single-cycle op: z latched at the next edge; done=1 in that cycle; remain in IDLE. Latency is 1.
  - IDLE & start & mul/div op: latch operands (magnitudes and sign flags for the signed variants), counter=0, go to ITER, busy=1.
  - ITER: one shift-add (mul) or restoring subtract-shift (div) step per cycle; after WIDTH steps go to FIN.
  - FIN: apply sign correction; write hi/lo and set z=lo; done=1, busy=0; return to IDLE.
  - Total mul/div latency: start edge to done = WIDTH+2 cycles (34 for WIDTH=32).
- start while busy: ignored; operands are not re-sampled. start in the FIN cycle: also ignored.
- done is exactly one cycle wide. z, zero, hi and lo hold between ops.
- ADD/SUB wrap modulo 2^WIDTH. SLT compares signed, correct across overflow: z = {0..., a<b}.
- Signed mul: product is the 2*WIDTH-bit two's complement result; hi=upper half, lo=lower half.
- Signed div: truncates toward zero. Quotient is negative iff operand signs differ; remainder takes the sign of the dividend.
- Division by zero: lo = all ones, hi = a (unsigned interpretation of the raw bits). Same latency, no exception.
- DIV of most-negative by -1: lo = most-negative, hi = 0.
- Reset mid-ITER: operation aborted; hi/lo return to 0; no done pulse.

Optional Feature:
- Macro Y_SEQ_ALU_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit), registered alongside z and cleared on reset.
  - ovf=1 for ADD/SUB signed overflow, asserted in the same cycle as done; z still holds the wrapped result.
  - ovf=0 for all other ops.
- When undefined: port absent, no overflow logic.

Decomposition:
- Package y_alu_pkg holds:
  - op code localparams (OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU);
  - the FSM state encoding (IDLE/ITER/FIN);
  - the divide-by-zero result constants.
- Sub-module y_mdu_iter contains the accumulator, shift registers and per-step add/subtract datapath. Its inputs are mode, load, step and the operands; its outputs are the raw magnitude hi/lo.
- The top level owns the FSM, counter, sign correction and output registers.

Test Plan:
- Reset, then ADD a=0x7FFFFFFF b=1 -> z=0x80000000 one cycle after start, done=1 for one cycle, zero=0. With OVF_EN: ovf=1.
- SUB a=5 b=5 -> z=0, zero=1. SLT a=0x80000000 b=1 -> z=1.
- MULT a=0xFFFFFFFE (-2) b=3 -> after 34 cycles: hi=0xFFFFFFFF, lo=0xFFFFFFFA, z=lo. MULTU with the same operands -> hi=0x2, lo=0xFFFFFFFA.
- DIV a=-7 b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU a=7 b=0 -> lo=0xFFFFFFFF, hi=7. DIV 0x80000000 by -1 -> lo=0x80000000, hi=0.
- start with DIVU 100/7 and hold start high with other ops throughout busy -> single done, lo=14, hi=2; no second launch until IDLE.
- Assert rst at cycle 10 of a MULT -> busy=0, hi=lo=z=0, no done. Then a fresh MULTU 3*4 completes with lo=12.
